riscv_hzrd_unit: RTL and testbench
==================================

RISCV_HZRD_UNIT -- requirements
Module: riscv_hzrd_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: i_riscv_hzrd_clk in 1 (all state updates on the rising edge); i_riscv_hzrd_rst in 1 (synchronous, active-high).
REQ-002 SHALL have i_riscv_hzrd_dstage_rs1addr in 5: decode-stage source register 1 address.
REQ-003 SHALL have i_riscv_hzrd_dstage_rs2addr in 5: decode-stage source register 2 address.
REQ-004 SHALL have i_riscv_hzrd_dstage_rdaddr in 5: decode-stage destination register address.
REQ-005 SHALL have i_riscv_hzrd_dstage_regw in 1: decode instruction writes rd.
REQ-006 SHALL have i_riscv_hzrd_dstage_memrd in 1: decode instruction is a load.
REQ-007 SHALL have i_riscv_hzrd_estage_branchtaken in 1: execute stage resolved taken branch/jump.
REQ-008 SHALL have o_riscv_hzrd_fwda out 2: execute forward select for operand A; 00 = register file, 01 = writeback data, 10 = memory-stage data; 11 never driven.
REQ-009 SHALL have o_riscv_hzrd_fwdb out 2: same encoding as fwda, for operand B.
REQ-010 SHALL have o_riscv_hzrd_stallf out 1: hold PC.
REQ-011 SHALL have o_riscv_hzrd_stalld out 1: hold F/D register.
REQ-012 SHALL have o_riscv_hzrd_flushd out 1: clear F/D register.
REQ-013 SHALL have o_riscv_hzrd_flushe out 1: clear D/E register.
REQ-014 SHALL have o_riscv_hzrd_stallcnt out 16: saturating count of load-use stall cycles.
REQ-015 SHALL have o_riscv_hzrd_flushcnt out 16: saturating count of branch flush cycles.

Function
REQ-016 SHALL keep an internal tag pipeline: E slot {rs1, rs2, rd, regw, memrd}, M slot {rd, regw, memrd}, W slot {rd, regw}.
REQ-017 SHALL advance the tag pipeline every cycle: W <= M, M <= E, and E <= decode inputs, or a bubble (all fields 0) when flushe=1.
REQ-018 SHALL compute fwda combinationally: 10 if M.regw & M.rd!=0 & M.rd==E.rs1; else 01 if W.regw & W.rd!=0 & W.rd==E.rs1; else 00. Memory stage has priority over writeback.
REQ-019 SHALL compute fwdb identically, using E.rs2.
REQ-020 SHALL never forward for x0: rd==0 always yields 00.
REQ-021 SHALL detect a load-use hazard (lu) when E.memrd & E.regw & E.rd!=0 & (E.rd==D.rs1 | E.rd==D.rs2).
REQ-022 SHALL assert stallf = stalld = lu & ~branchtaken.
REQ-023 SHALL assert flushe = lu | branchtaken.
REQ-024 SHALL assert flushd = branchtaken.
REQ-025 SHALL resolve simultaneous lu and branchtaken as a branch: no stall, flushd=flushe=1.
REQ-026 SHALL make the load-use stall exactly 1 cycle; on the next cycle the load sits in M, lu=0, and the consumer later receives fwd=01 from W.
REQ-027 SHALL increment stallcnt on each cycle with stallf=1, and flushcnt on each cycle with flushd=1; both saturate at 16'hFFFF with no wrap.
REQ-028 SHALL use no combinational path from outputs back to inputs; fwda/fwdb depend on state only.

Reset
REQ-029 SHALL, while rst=1, on each clock edge clear all tag slots to bubble and both counters to 0.
REQ-030 SHALL, while rst=1, force stallf, stalld, flushd and flushe to 0 regardless of inputs.
REQ-031 SHALL drive fwda = fwdb = 00 from the first cycle after reset.
REQ-032 SHALL discard in-flight tags on a mid-operation reset; no forward selects survive into the first post-reset cycle.

Verification
REQ-033 ALU-ALU forward: add x5 issued, then add x6,x5,x1 next cycle -> fwda=10 while the consumer is in E.
REQ-034 Writeback forward: x5 producer, one independent instruction, then consumer of x5 in rs2 -> fwdb=01; with both M and W writing x5 -> fwdb=10.
REQ-035 Load-use: lw x7, then add x8,x7,x7 -> exactly one cycle of stallf=stalld=flushe=1, stallcnt=1, then fwda=fwdb=01 for the consumer.
REQ-036 Branch with load-use: hold a load-use condition and assert branchtaken in the same cycle -> stallf=0, flushd=flushe=1, flushcnt increments, stallcnt unchanged.
REQ-037 x0 and saturation: producer writing x0 followed by a reader of x0 -> fwd=00; force flushcnt to FFFF with branchtaken held -> count stays FFFF.
REQ-038 Reset mid-stream: assert rst for 1 cycle during a forwarding sequence -> stall/flush outputs 0 during reset, counters 0, fwda=fwdb=00 the cycle after.

Source files
------------

// File: rtl/riscv_hzrd_unit.sv
// Pipeline hazard unit: tracks register tags through E/M/W, selects operand
// forwarding, and raises stall/flush controls with saturating event counters.
module riscv_hzrd_unit (
    input  logic        i_riscv_hzrd_clk,
    input  logic        i_riscv_hzrd_rst,
    input  logic [4:0]  i_riscv_hzrd_dstage_rs1addr,
    input  logic [4:0]  i_riscv_hzrd_dstage_rs2addr,
    input  logic [4:0]  i_riscv_hzrd_dstage_rdaddr,
    input  logic        i_riscv_hzrd_dstage_regw,
    input  logic        i_riscv_hzrd_dstage_memrd,
    input  logic        i_riscv_hzrd_estage_branchtaken,
    output logic [1:0]  o_riscv_hzrd_fwda,
    output logic [1:0]  o_riscv_hzrd_fwdb,
    output logic        o_riscv_hzrd_stallf,
    output logic        o_riscv_hzrd_stalld,
    output logic        o_riscv_hzrd_flushd,
    output logic        o_riscv_hzrd_flushe,
    output logic [15:0] o_riscv_hzrd_stallcnt,
    output logic [15:0] o_riscv_hzrd_flushcnt
);

    logic [4:0] e_rs1_reg, e_rs2_reg, e_rd_reg;
    logic       e_regw_reg, e_memrd_reg;
    logic [4:0] m_rd_reg;
    logic       m_regw_reg;
    logic [4:0] w_rd_reg;
    logic       w_regw_reg;

    logic load_use;
    logic stall;
    logic flush_d;
    logic flush_e;

    // A load in E whose destination is read by the instruction in D.
    assign load_use = e_memrd_reg & e_regw_reg & (e_rd_reg != 5'd0) &
                      ((e_rd_reg == i_riscv_hzrd_dstage_rs1addr) |
                       (e_rd_reg == i_riscv_hzrd_dstage_rs2addr));

    assign stall   = load_use & ~i_riscv_hzrd_estage_branchtaken & ~i_riscv_hzrd_rst;
    assign flush_d = i_riscv_hzrd_estage_branchtaken & ~i_riscv_hzrd_rst;
    assign flush_e = (load_use | i_riscv_hzrd_estage_branchtaken) & ~i_riscv_hzrd_rst;

    assign o_riscv_hzrd_stallf = stall;
    assign o_riscv_hzrd_stalld = stall;
    assign o_riscv_hzrd_flushd = flush_d;
    assign o_riscv_hzrd_flushe = flush_e;

    always_ff @(posedge i_riscv_hzrd_clk) begin
        if (i_riscv_hzrd_rst) begin
            e_rs1_reg   <= 5'd0;
            e_rs2_reg   <= 5'd0;
            e_rd_reg    <= 5'd0;
            e_regw_reg  <= 1'b0;
            e_memrd_reg <= 1'b0;
            m_rd_reg    <= 5'd0;
            m_regw_reg  <= 1'b0;
            w_rd_reg    <= 5'd0;
            w_regw_reg  <= 1'b0;
        end else begin
            w_rd_reg   <= m_rd_reg;
            w_regw_reg <= m_regw_reg;
            m_rd_reg   <= e_rd_reg;
            m_regw_reg <= e_regw_reg;
            if (flush_e) begin
                e_rs1_reg   <= 5'd0;
                e_rs2_reg   <= 5'd0;
                e_rd_reg    <= 5'd0;
                e_regw_reg  <= 1'b0;
                e_memrd_reg <= 1'b0;
            end else begin
                e_rs1_reg   <= i_riscv_hzrd_dstage_rs1addr;
                e_rs2_reg   <= i_riscv_hzrd_dstage_rs2addr;
                e_rd_reg    <= i_riscv_hzrd_dstage_rdaddr;
                e_regw_reg  <= i_riscv_hzrd_dstage_regw;
                e_memrd_reg <= i_riscv_hzrd_dstage_memrd;
            end
        end
    end

    // Forward selects: operand 0 is rs1, operand 1 is rs2; M outranks W.
    logic [4:0] e_src   [2];
    logic [1:0] fwd_sel [2];

    assign e_src[0] = e_rs1_reg;
    assign e_src[1] = e_rs2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic m_hit;
            logic w_hit;
            assign m_hit = m_regw_reg & (m_rd_reg != 5'd0) & (m_rd_reg == e_src[gi]);
            assign w_hit = w_regw_reg & (w_rd_reg != 5'd0) & (w_rd_reg == e_src[gi]);
            assign fwd_sel[gi] = m_hit ? 2'b10 : (w_hit ? 2'b01 : 2'b00);
        end
    endgenerate

    assign o_riscv_hzrd_fwda = fwd_sel[0];
    assign o_riscv_hzrd_fwdb = fwd_sel[1];

    // Event counters: 0 counts stall cycles, 1 counts branch flush cycles.
    logic        cnt_inc [2];
    logic [15:0] cnt_out [2];

    assign cnt_inc[0] = stall;
    assign cnt_inc[1] = flush_d;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            logic [15:0] cnt_next;
            assign cnt_next = (cnt_inc[gi] && (cnt_reg != 16'hFFFF)) ? cnt_reg + 16'd1 : cnt_reg;
            always_ff @(posedge i_riscv_hzrd_clk) begin
                if (i_riscv_hzrd_rst) begin
                    cnt_reg <= 16'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
            assign cnt_out[gi] = cnt_reg;
        end
    endgenerate

    assign o_riscv_hzrd_stallcnt = cnt_out[0];
    assign o_riscv_hzrd_flushcnt = cnt_out[1];

endmodule

// File: tb/tb_riscv_hzrd_unit.sv
// Self-checking bench for riscv_hzrd_unit: directed hazard scenarios plus
// randomized traffic compared against an instruction-window reference model.
module tb_riscv_hzrd_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        regw, memrd, bt;
    logic [1:0]  fwda, fwdb;
    logic        stallf, stalld, flushd, flushe;
    logic [15:0] stallcnt, flushcnt;

    always #5 clk = ~clk;

    riscv_hzrd_unit dut (
        .i_riscv_hzrd_clk               (clk),
        .i_riscv_hzrd_rst               (rst),
        .i_riscv_hzrd_dstage_rs1addr    (rs1),
        .i_riscv_hzrd_dstage_rs2addr    (rs2),
        .i_riscv_hzrd_dstage_rdaddr     (rd),
        .i_riscv_hzrd_dstage_regw       (regw),
        .i_riscv_hzrd_dstage_memrd      (memrd),
        .i_riscv_hzrd_estage_branchtaken(bt),
        .o_riscv_hzrd_fwda              (fwda),
        .o_riscv_hzrd_fwdb              (fwdb),
        .o_riscv_hzrd_stallf            (stallf),
        .o_riscv_hzrd_stalld            (stalld),
        .o_riscv_hzrd_flushd            (flushd),
        .o_riscv_hzrd_flushe            (flushe),
        .o_riscv_hzrd_stallcnt          (stallcnt),
        .o_riscv_hzrd_flushcnt          (flushcnt)
    );

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regw;
        logic       memrd;
    } instr_t;

    // window[0] is the instruction in execute, window[1]/[2] are one and two
    // instructions older (memory and writeback).
    instr_t      window[$];
    instr_t      bubble;
    int          errors = 0;
    int          checks = 0;
    int unsigned m_stallcnt = 0;
    int unsigned m_flushcnt = 0;
    logic [1:0]  exp_fwda, exp_fwdb;
    logic        exp_stall, exp_flushd, exp_flushe;

    // Nearest older producer of src wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_for(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            if (window[age].regw && window[age].rd == src)
                return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic apply(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic w, input logic m, input logic br, input logic r);
        logic lu;
        rs1 = a; rs2 = b; rd = d; regw = w; memrd = m; bt = br; rst = r;
        @(negedge clk);
        lu = window[0].memrd && window[0].regw && (window[0].rd != 5'd0) &&
             (window[0].rd == a || window[0].rd == b);
        exp_fwda   = fwd_for(window[0].rs1);
        exp_fwdb   = fwd_for(window[0].rs2);
        exp_stall  = lu && !br && !r;
        exp_flushd = br && !r;
        exp_flushe = (lu || br) && !r;
    endtask

    task automatic advance();
        instr_t nxt;
        @(posedge clk);
        if (rst) begin
            window = {};
            for (int i = 0; i < 3; i++) window.push_back(bubble);
            m_stallcnt = 0;
            m_flushcnt = 0;
        end else begin
            if (exp_stall && m_stallcnt < 65535) m_stallcnt++;
            if (exp_flushd && m_flushcnt < 65535) m_flushcnt++;
            nxt.rs1 = rs1; nxt.rs2 = rs2; nxt.rd = rd; nxt.regw = regw; nxt.memrd = memrd;
            window.push_front(exp_flushe ? bubble : nxt);
            void'(window.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        apply(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        $display("reset: rst=1 bt=1 stallf=%b flushd=%b flushe=%b", stallf, flushd, flushe);
        checks++; if (stallf !== 1'b0) begin errors++; $display("FAIL reset_stallf: got %b expected 0", stallf); end
        checks++; if (stalld !== 1'b0) begin errors++; $display("FAIL reset_stalld: got %b expected 0", stalld); end
        checks++; if (flushd !== 1'b0) begin errors++; $display("FAIL reset_flushd: got %b expected 0", flushd); end
        checks++; if (flushe !== 1'b0) begin errors++; $display("FAIL reset_flushe: got %b expected 0", flushe); end
        advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("post-reset: fwda=%b fwdb=%b stallcnt=%0d flushcnt=%0d", fwda, fwdb, stallcnt, flushcnt);
        checks++; if (fwda !== 2'b00) begin errors++; $display("FAIL reset_fwda: got %b expected 00", fwda); end
        checks++; if (fwdb !== 2'b00) begin errors++; $display("FAIL reset_fwdb: got %b expected 00", fwdb); end
        checks++; if (stallcnt !== 16'd0) begin errors++; $display("FAIL reset_stallcnt: got %0d expected 0", stallcnt); end
        checks++; if (flushcnt !== 16'd0) begin errors++; $display("FAIL reset_flushcnt: got %0d expected 0", flushcnt); end
        advance();
    endtask

    task automatic test_alu_fwd();
        apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("alu_fwd: add x6,x5,x1 in E fwda=%b fwdb=%b", fwda, fwdb);
        checks++; if (fwda !== 2'b10) begin errors++; $display("FAIL alu_fwda: got %b expected 10", fwda); end
        checks++; if (fwda !== exp_fwda) begin errors++; $display("FAIL alu_fwda_model: got %b expected %b", fwda, exp_fwda); end
        checks++; if (fwdb !== exp_fwdb) begin errors++; $display("FAIL alu_fwdb_model: got %b expected %b", fwdb, exp_fwdb); end
        advance();
    endtask

    task automatic test_wb_fwd();
        apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd10, 5'd11, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd3, 5'd5, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("wb_fwd: consumer of x5 two behind fwda=%b fwdb=%b", fwda, fwdb);
        checks++; if (fwdb !== 2'b01) begin errors++; $display("FAIL wb_fwdb: got %b expected 01", fwdb); end
        checks++; if (fwda !== exp_fwda) begin errors++; $display("FAIL wb_fwda_model: got %b expected %b", fwda, exp_fwda); end
        advance();
        apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd6, 5'd5, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("wb_fwd: x5 written in M and W fwdb=%b", fwdb);
        checks++; if (fwdb !== 2'b10) begin errors++; $display("FAIL mw_fwdb: got %b expected 10", fwdb); end
        checks++; if (fwdb !== exp_fwdb) begin errors++; $display("FAIL mw_fwdb_model: got %b expected %b", fwdb, exp_fwdb); end
        advance();
    endtask

    task automatic test_load_use();
        int unsigned s0;
        apply(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0); advance();
        s0 = m_stallcnt;
        apply(5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("load_use: stall cycle stallf=%b stalld=%b flushe=%b flushd=%b", stallf, stalld, flushe, flushd);
        checks++; if (stallf !== 1'b1) begin errors++; $display("FAIL lu_stallf: got %b expected 1", stallf); end
        checks++; if (stalld !== 1'b1) begin errors++; $display("FAIL lu_stalld: got %b expected 1", stalld); end
        checks++; if (flushe !== 1'b1) begin errors++; $display("FAIL lu_flushe: got %b expected 1", flushe); end
        checks++; if (flushd !== 1'b0) begin errors++; $display("FAIL lu_flushd: got %b expected 0", flushd); end
        advance();
        apply(5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("load_use: released stallf=%b stallcnt=%0d", stallf, stallcnt);
        checks++; if (stallf !== 1'b0) begin errors++; $display("FAIL lu_release_stallf: got %b expected 0", stallf); end
        checks++; if (flushe !== 1'b0) begin errors++; $display("FAIL lu_release_flushe: got %b expected 0", flushe); end
        checks++; if (stallcnt !== 16'(s0 + 1)) begin errors++; $display("FAIL lu_stallcnt: got %0d expected %0d", stallcnt, s0 + 1); end
        advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("load_use: consumer in E fwda=%b fwdb=%b", fwda, fwdb);
        checks++; if (fwda !== 2'b01) begin errors++; $display("FAIL lu_fwda: got %b expected 01", fwda); end
        checks++; if (fwdb !== 2'b01) begin errors++; $display("FAIL lu_fwdb: got %b expected 01", fwdb); end
        advance();
    endtask

    task automatic test_branch_lu();
        int unsigned s0, f0;
        apply(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0); advance();
        s0 = m_stallcnt; f0 = m_flushcnt;
        apply(5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        $display("branch_lu: stallf=%b flushd=%b flushe=%b", stallf, flushd, flushe);
        checks++; if (stallf !== 1'b0) begin errors++; $display("FAIL blu_stallf: got %b expected 0", stallf); end
        checks++; if (stalld !== 1'b0) begin errors++; $display("FAIL blu_stalld: got %b expected 0", stalld); end
        checks++; if (flushd !== 1'b1) begin errors++; $display("FAIL blu_flushd: got %b expected 1", flushd); end
        checks++; if (flushe !== 1'b1) begin errors++; $display("FAIL blu_flushe: got %b expected 1", flushe); end
        advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("branch_lu: after stallcnt=%0d flushcnt=%0d", stallcnt, flushcnt);
        checks++; if (flushcnt !== 16'(f0 + 1)) begin errors++; $display("FAIL blu_flushcnt: got %0d expected %0d", flushcnt, f0 + 1); end
        checks++; if (stallcnt !== 16'(s0)) begin errors++; $display("FAIL blu_stallcnt: got %0d expected %0d", stallcnt, s0); end
        advance();
    endtask

    task automatic test_x0();
        apply(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("x0: reader of x0 fwda=%b fwdb=%b", fwda, fwdb);
        checks++; if (fwda !== 2'b00) begin errors++; $display("FAIL x0_fwda: got %b expected 00", fwda); end
        checks++; if (fwdb !== 2'b00) begin errors++; $display("FAIL x0_fwdb: got %b expected 00", fwdb); end
        advance();
        apply(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0); advance();
        apply(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("x0: load to x0 then reader stallf=%b", stallf);
        checks++; if (stallf !== 1'b0) begin errors++; $display("FAIL x0_lu_stallf: got %b expected 0", stallf); end
        advance();
    endtask

    task automatic test_reset_mid();
        apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); advance();
        apply(5'd5, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
        $display("reset_mid: during rst stallf=%b flushd=%b flushe=%b fwda=%b", stallf, flushd, flushe, fwda);
        checks++; if (stallf !== 1'b0) begin errors++; $display("FAIL rmid_stallf: got %b expected 0", stallf); end
        checks++; if (flushd !== 1'b0) begin errors++; $display("FAIL rmid_flushd: got %b expected 0", flushd); end
        checks++; if (flushe !== 1'b0) begin errors++; $display("FAIL rmid_flushe: got %b expected 0", flushe); end
        checks++; if (fwda !== exp_fwda) begin errors++; $display("FAIL rmid_fwda_model: got %b expected %b", fwda, exp_fwda); end
        advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("reset_mid: after fwda=%b fwdb=%b stallcnt=%0d flushcnt=%0d", fwda, fwdb, stallcnt, flushcnt);
        checks++; if (fwda !== 2'b00) begin errors++; $display("FAIL rmid_fwda: got %b expected 00", fwda); end
        checks++; if (fwdb !== 2'b00) begin errors++; $display("FAIL rmid_fwdb: got %b expected 00", fwdb); end
        checks++; if (stallcnt !== 16'd0) begin errors++; $display("FAIL rmid_stallcnt: got %0d expected 0", stallcnt); end
        checks++; if (flushcnt !== 16'd0) begin errors++; $display("FAIL rmid_flushcnt: got %0d expected 0", flushcnt); end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) == 0));
            $display("rand %0d: rs1=%0d rs2=%0d rd=%0d w=%b m=%b bt=%b rst=%b -> fa=%b fb=%b st=%b fd=%b fe=%b sc=%0d fc=%0d",
                     n, rs1, rs2, rd, regw, memrd, bt, rst, fwda, fwdb, stallf, flushd, flushe, stallcnt, flushcnt);
            checks++; if (fwda !== exp_fwda) begin errors++; $display("FAIL rand_fwda: got %b expected %b", fwda, exp_fwda); end
            checks++; if (fwdb !== exp_fwdb) begin errors++; $display("FAIL rand_fwdb: got %b expected %b", fwdb, exp_fwdb); end
            checks++; if (stallf !== exp_stall) begin errors++; $display("FAIL rand_stallf: got %b expected %b", stallf, exp_stall); end
            checks++; if (stalld !== exp_stall) begin errors++; $display("FAIL rand_stalld: got %b expected %b", stalld, exp_stall); end
            checks++; if (flushd !== exp_flushd) begin errors++; $display("FAIL rand_flushd: got %b expected %b", flushd, exp_flushd); end
            checks++; if (flushe !== exp_flushe) begin errors++; $display("FAIL rand_flushe: got %b expected %b", flushe, exp_flushe); end
            checks++; if (stallcnt !== 16'(m_stallcnt)) begin errors++; $display("FAIL rand_stallcnt: got %0d expected %0d", stallcnt, m_stallcnt); end
            checks++; if (flushcnt !== 16'(m_flushcnt)) begin errors++; $display("FAIL rand_flushcnt: got %0d expected %0d", flushcnt, m_flushcnt); end
            advance();
        end
    endtask

    task automatic test_saturation();
        int unsigned s0;
        s0 = m_stallcnt;
        for (int n = 0; n < 65540; n++) begin
            apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            advance();
        end
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("saturation: flushcnt=%h stallcnt=%0d", flushcnt, stallcnt);
        checks++; if (flushcnt !== 16'hFFFF) begin errors++; $display("FAIL sat_flushcnt: got %h expected FFFF", flushcnt); end
        checks++; if (flushcnt !== 16'(m_flushcnt)) begin errors++; $display("FAIL sat_flushcnt_model: got %h expected %h", flushcnt, 16'(m_flushcnt)); end
        checks++; if (stallcnt !== 16'(s0)) begin errors++; $display("FAIL sat_stallcnt: got %0d expected %0d", stallcnt, s0); end
        advance();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("saturation: held flushcnt=%h", flushcnt);
        checks++; if (flushcnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_flushcnt: got %h expected FFFF", flushcnt); end
        advance();
    endtask

    initial begin
        bubble = '0;
        window = {};
        for (int i = 0; i < 3; i++) window.push_back(bubble);
        rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; regw = 1'b0; memrd = 1'b0; bt = 1'b0;
        test_reset();
        test_alu_fwd();
        test_wb_fwd();
        test_load_use();
        test_branch_lu();
        test_x0();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
